fetch_unit: RTL and testbench

//   Instruction fetch stage directly upstream of the controller. Owns the PC,

---
 rtl/fetch_unit_if.sv | 24 ++
 rtl/fetch_unit.sv | 144 ++++++++++++++
 tb/tb_fetch_unit.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction memory req/ack bus between fetch unit and imem
interface fetch_unit_if #(
    parameter int N = 32,
    parameter int M = 16
);
    logic         imem_req;
    logic [M-1:0] imem_addr;
    logic         imem_ack;
    logic [N-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC owner, imem fetch handshake, jz/jg branch resolution, halt
module fetch_unit #(
    parameter int           N        = 32,
    parameter int           M        = 16,
    parameter logic [M-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_unit_if.master  imem,
    output logic [N-1:0]  instr,
    output logic          instr_valid,
    input  logic          stall,
    output logic [M-1:0]  pc_out,
    input  logic          is_jz,
    input  logic          is_jg,
    input  logic          is_halted,
    input  logic          br_resolve,
    input  logic          cond_zero,
    input  logic          cond_greater,
    input  logic [M-1:0]  br_target,
    output logic          halted
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        ISSUE,
        BRANCH,
        HALT
    } state_t;

    localparam logic [M-1:0] PC_STEP = M'(1);

    state_t       state, state_nx;
    logic [M-1:0] pc, pc_nx, pc_inc;
    logic         req_q, req_nx;
    logic [M-1:0] addr_q, addr_nx;
    logic [N-1:0] instr_nx;
    logic         valid_nx;
    logic [M-1:0] pc_out_nx;
    logic         halted_nx;
    logic         jz_lat, jz_lat_nx;
    logic         jg_lat, jg_lat_nx;
    logic         taken;

    assign pc_inc = pc + PC_STEP;
    // Both latched types are evaluated so a combined jz|jg decode fires on either condition.
    assign taken  = (jz_lat & cond_zero) | (jg_lat & cond_greater);

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = addr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            req_q       <= 1'b0;
            addr_q      <= RESET_PC;
            instr       <= '0;
            instr_valid <= 1'b0;
            pc_out      <= '0;
            halted      <= 1'b0;
            jz_lat      <= 1'b0;
            jg_lat      <= 1'b0;
        end else begin
            state       <= state_nx;
            pc          <= pc_nx;
            req_q       <= req_nx;
            addr_q      <= addr_nx;
            instr       <= instr_nx;
            instr_valid <= valid_nx;
            pc_out      <= pc_out_nx;
            halted      <= halted_nx;
            jz_lat      <= jz_lat_nx;
            jg_lat      <= jg_lat_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        pc_nx     = pc;
        req_nx    = req_q;
        addr_nx   = addr_q;
        instr_nx  = instr;
        valid_nx  = instr_valid;
        pc_out_nx = pc_out;
        halted_nx = halted;
        jz_lat_nx = jz_lat;
        jg_lat_nx = jg_lat;

        case (state)
            IDLE: begin
                state_nx = REQ;
                req_nx   = 1'b1;
                addr_nx  = pc;
            end
            REQ: begin
                if (imem.imem_ack) begin
                    instr_nx  = imem.imem_rdata;
                    pc_out_nx = pc;
                    valid_nx  = 1'b1;
                    req_nx    = 1'b0;
                    state_nx  = ISSUE;
                end
            end
            ISSUE: begin
                if (!stall) begin
                    valid_nx = 1'b0;
                    if (is_halted) begin
                        halted_nx = 1'b1;
                        state_nx  = HALT;
                    end else if (is_jz || is_jg) begin
                        jz_lat_nx = is_jz;
                        jg_lat_nx = is_jg;
                        state_nx  = BRANCH;
                    end else begin
                        pc_nx    = pc_inc;
                        addr_nx  = pc_inc;
                        req_nx   = 1'b1;
                        state_nx = REQ;
                    end
                end
            end
            BRANCH: begin
                if (br_resolve) begin
                    pc_nx    = taken ? br_target : pc_inc;
                    addr_nx  = taken ? br_target : pc_inc;
                    req_nx   = 1'b1;
                    state_nx = REQ;
                end
            end
            HALT: begin
                req_nx   = 1'b0;
                valid_nx = 1'b0;
            end
            default: begin
                state_nx = IDLE;
                req_nx   = 1'b0;
                valid_nx = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized self-checking bench for fetch_unit against a PC-level model
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rst2_n;
    logic        stall;
    logic        is_jz, is_jg, is_halted;
    logic        br_resolve, cond_zero, cond_greater;
    logic [15:0] br_target;

    logic [31:0] instr, instr2;
    logic        instr_valid, instr_valid2;
    logic [15:0] pc_out, pc_out2;
    logic        halted, halted2;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] mpc;

    fetch_unit_if #(.N(32), .M(16)) bus ();
    fetch_unit_if #(.N(32), .M(16)) bus2 ();

    fetch_unit #(.N(32), .M(16), .RESET_PC(16'h0000)) dut (
        .clk(clk), .rst_n(rst_n), .imem(bus.master),
        .instr(instr), .instr_valid(instr_valid), .stall(stall), .pc_out(pc_out),
        .is_jz(is_jz), .is_jg(is_jg), .is_halted(is_halted),
        .br_resolve(br_resolve), .cond_zero(cond_zero), .cond_greater(cond_greater),
        .br_target(br_target), .halted(halted)
    );

    fetch_unit #(.N(32), .M(16), .RESET_PC(16'hFFFF)) dut2 (
        .clk(clk), .rst_n(rst2_n), .imem(bus2.master),
        .instr(instr2), .instr_valid(instr_valid2), .stall(stall), .pc_out(pc_out2),
        .is_jz(is_jz), .is_jg(is_jg), .is_halted(is_halted),
        .br_resolve(br_resolve), .cond_zero(cond_zero), .cond_greater(cond_greater),
        .br_target(br_target), .halted(halted2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_req();
        int k = 0;
        while (bus.imem_req !== 1'b1 && k < 8) begin
            @(negedge clk);
            k++;
        end
        check("req_timeout", 32'(bus.imem_req), 32'd1);
    endtask

    task automatic serve(input logic [31:0] word, input int lat);
        wait_req();
        check("fetch_addr", 32'(bus.imem_addr), 32'(mpc));
        check("not_halted", 32'(halted), 32'd0);
        for (int i = 0; i < lat; i++) begin
            bus.imem_ack = 1'b0;
            @(negedge clk);
            check("req_hold", 32'(bus.imem_req), 32'd1);
            check("addr_hold", 32'(bus.imem_addr), 32'(mpc));
        end
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = word;
        @(negedge clk);
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = $urandom;
        check("valid", 32'(instr_valid), 32'd1);
        check("instr", instr, word);
        check("pc_out", 32'(pc_out), 32'(mpc));
        check("req_drop", 32'(bus.imem_req), 32'd0);
    endtask

    task automatic consume(input int stalls, input bit h, input bit jz, input bit jg,
                           input logic [31:0] word);
        for (int i = 0; i < stalls; i++) begin
            stall         = 1'b1;
            is_halted     = 1'($urandom);
            is_jz         = 1'($urandom);
            is_jg         = 1'($urandom);
            bus.imem_ack  = 1'($urandom);
            @(negedge clk);
            check("stall_valid", 32'(instr_valid), 32'd1);
            check("stall_instr", instr, word);
            check("stall_pc_out", 32'(pc_out), 32'(mpc));
            check("stall_no_req", 32'(bus.imem_req), 32'd0);
        end
        stall        = 1'b0;
        is_halted    = h;
        is_jz        = jz;
        is_jg        = jg;
        bus.imem_ack = 1'b0;
        @(negedge clk);
        is_halted = 1'b0;
        is_jz     = 1'b0;
        is_jg     = 1'b0;
        stall     = 1'($urandom);
        check("valid_drop", 32'(instr_valid), 32'd0);
        if (h) begin
            check("halted_set", 32'(halted), 32'd1);
            check("halt_no_req", 32'(bus.imem_req), 32'd0);
        end else if (jz || jg) begin
            check("branch_no_req", 32'(bus.imem_req), 32'd0);
        end else begin
            mpc = mpc + 16'd1;
            check("next_req", 32'(bus.imem_req), 32'd1);
        end
    endtask

    task automatic resolve(input int dly, input bit jz, input bit jg, input bit cz,
                           input bit cg, input logic [15:0] tgt);
        for (int i = 0; i < dly; i++) begin
            br_resolve   = 1'b0;
            cond_zero    = 1'($urandom);
            cond_greater = 1'($urandom);
            br_target    = 16'($urandom);
            bus.imem_ack = 1'($urandom);
            @(negedge clk);
            check("br_no_req", 32'(bus.imem_req), 32'd0);
            check("br_no_valid", 32'(instr_valid), 32'd0);
        end
        br_resolve   = 1'b1;
        cond_zero    = cz;
        cond_greater = cg;
        br_target    = tgt;
        bus.imem_ack = 1'b0;
        @(negedge clk);
        br_resolve = 1'b0;
        mpc = ((jz && cz) || (jg && cg)) ? tgt : mpc + 16'd1;
    endtask

    task automatic run_instr(input logic [31:0] word, input int lat, input int stalls,
                             input bit jz, input bit jg, input bit cz, input bit cg,
                             input logic [15:0] tgt, input int dly);
        serve(word, lat);
        consume(stalls, 1'b0, jz, jg, word);
        if (jz || jg) resolve(dly, jz, jg, cz, cg, tgt);
    endtask

    initial begin
        logic [31:0] w;
        int          k;
        rst_n = 1'b0; rst2_n = 1'b0;
        stall = 1'b0; is_jz = 1'b0; is_jg = 1'b0; is_halted = 1'b0;
        br_resolve = 1'b0; cond_zero = 1'b0; cond_greater = 1'b0; br_target = '0;
        bus.imem_ack = 1'b0; bus.imem_rdata = '0;
        bus2.imem_ack = 1'b0; bus2.imem_rdata = '0;
        mpc = 16'h0000;
        repeat (2) @(negedge clk);
        check("rst_req", 32'(bus.imem_req), 32'd0);
        check("rst_addr", 32'(bus.imem_addr), 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_pc_out", 32'(pc_out), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 3; i++) run_instr(32'h8000_0000 + 32'(i), 0, 0, 0, 0, 0, 0, '0, 0);

        // Reset while the fetch at address 3 is still waiting for its ack.
        wait_req();
        check("addr3", 32'(bus.imem_addr), 32'd3);
        @(negedge clk);
        #2 rst_n = 1'b0;
        bus.imem_ack = 1'b1;
        bus.imem_rdata = 32'hDEAD_BEEF;
        #1;
        check("async_req", 32'(bus.imem_req), 32'd0);
        check("async_addr", 32'(bus.imem_addr), 32'd0);
        check("async_valid", 32'(instr_valid), 32'd0);
        check("async_pc_out", 32'(pc_out), 32'd0);
        check("async_instr", instr, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus.imem_ack = 1'b0;
        check("late_ack_valid", 32'(instr_valid), 32'd0);
        check("restart_req", 32'(bus.imem_req), 32'd1);
        check("restart_addr", 32'(bus.imem_addr), 32'd0);
        mpc = 16'h0000;

        serve(32'h1234_5678, 0);
        consume(3, 1'b0, 1'b0, 1'b0, 32'h1234_5678);
        for (int i = 1; i < 5; i++) run_instr($urandom, 0, 0, 0, 0, 0, 0, '0, 0);
        check("at_pc5", 32'(mpc), 32'd5);
        run_instr(32'hA000_0005, 1, 0, 1, 0, 1, 0, 16'h0020, 1);
        check("jz_taken_model", 32'(mpc), 32'h20);
        run_instr(32'hA000_0020, 0, 0, 1, 0, 1, 0, 16'h0005, 0);
        run_instr(32'hA000_0005, 0, 0, 1, 0, 0, 1, 16'h0020, 2);
        check("jz_not_taken_model", 32'(mpc), 32'd6);
        serve(32'hA000_0006, 0);
        consume(0, 1'b0, 1'b0, 1'b0, 32'hA000_0006);

        for (int i = 0; i < 60; i++) begin
            k = $urandom_range(0, 9);
            run_instr($urandom, $urandom_range(0, 3), $urandom_range(0, 2),
                      (k == 7 || k == 9), (k == 8 || k == 9),
                      1'($urandom), 1'($urandom), 16'($urandom), $urandom_range(0, 3));
        end

        w = $urandom;
        serve(w, 1);
        consume(1, 1'b1, 1'b1, 1'b0, w);
        for (int i = 0; i < 20; i++) begin
            bus.imem_ack = 1'($urandom);
            stall        = 1'($urandom);
            is_jz        = 1'($urandom);
            br_resolve   = 1'($urandom);
            @(negedge clk);
            check("halt_req", 32'(bus.imem_req), 32'd0);
            check("halt_stay", 32'(halted), 32'd1);
            check("halt_valid", 32'(instr_valid), 32'd0);
        end
        bus.imem_ack = 1'b0; stall = 1'b0; is_jz = 1'b0; br_resolve = 1'b0;

        // Second instance starts at the top of the address space and must wrap.
        rst2_n = 1'b1;
        k = 0;
        while (bus2.imem_req !== 1'b1 && k < 8) begin
            @(negedge clk);
            k++;
        end
        check("wrap_req", 32'(bus2.imem_req), 32'd1);
        check("wrap_addr0", 32'(bus2.imem_addr), 32'hFFFF);
        w = $urandom;
        bus2.imem_ack = 1'b1;
        bus2.imem_rdata = w;
        @(negedge clk);
        bus2.imem_ack = 1'b0;
        check("wrap_valid", 32'(instr_valid2), 32'd1);
        check("wrap_instr", instr2, w);
        check("wrap_pc_out", 32'(pc_out2), 32'hFFFF);
        @(negedge clk);
        check("wrap_req2", 32'(bus2.imem_req), 32'd1);
        check("wrap_addr1", 32'(bus2.imem_addr), 32'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
